sound_event_player: RTL

//  Event-driven tone player for the game audio path. Maps game events (bad collision, good

---
 rtl/sound_event_player_if.sv | 24 ++
 rtl/sound_event_player.sv | 101 ++++++++++
 2 files changed

// File: rtl/sound_event_player_if.sv
// Event/tone bundle for sound_event_player: game events and mute in, tone state and wave out.
interface sound_event_player_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned DIR_W = 4
);
  logic             bad_coll_i;
  logic             good_coll_i;
  logic [DIR_W-1:0] direction_i;
  logic             mute_i;
  logic             busy_o;
  logic [DIV_W-1:0] div_o;
  logic [7:0]       phase_o;
  logic             wave_o;

  modport master (
    output bad_coll_i, good_coll_i, direction_i, mute_i,
    input  busy_o, div_o, phase_o, wave_o
  );

  modport slave (
    input  bad_coll_i, good_coll_i, direction_i, mute_i,
    output busy_o, div_o, phase_o, wave_o
  );
endinterface

// File: rtl/sound_event_player.sv
// Event-driven square-wave tone player: bad > good > move priority, retrigger on equal or
// higher priority, fixed per-event duration and divider.
module sound_event_player #(
  parameter int unsigned     DIV_W    = 8,
  parameter int unsigned     DIR_W    = 4,
  parameter logic [DIV_W-1:0] DIV_BAD  = DIV_W'(126),
  parameter logic [DIV_W-1:0] DIV_GOOD = DIV_W'(89),
  parameter logic [DIV_W-1:0] DIV_MOVE = DIV_W'(149),
  parameter int unsigned     DUR_W    = 22,
  parameter int unsigned     COLL_DUR = 2500000,
  parameter int unsigned     MOVE_DUR = 500000
) (
  input logic                  clk,
  input logic                  rst,
  sound_event_player_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  logic [0:0]       r_state;
  logic [DIR_W-1:0] r_dir_q;
  logic [1:0]       r_cur_p;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic [7:0]       r_phase;

  logic             w_move;
  logic [1:0]       w_p;
  logic [DIV_W-1:0] w_div_sel;
  logic [DUR_W-1:0] w_dur_sel;
  logic             w_accept;
  logic [DIV_W-1:0] w_div_last;

  always_comb begin
    w_move    = (bus.direction_i != r_dir_q) && (bus.direction_i != '0);
    w_p       = 2'd0;
    w_div_sel = '0;
    w_dur_sel = DUR_W'(MOVE_DUR - 1);
    if (bus.bad_coll_i) begin
      w_p       = 2'd3;
      w_div_sel = DIV_BAD;
      w_dur_sel = DUR_W'(COLL_DUR - 1);
    end else if (bus.good_coll_i) begin
      w_p       = 2'd2;
      w_div_sel = DIV_GOOD;
      w_dur_sel = DUR_W'(COLL_DUR - 1);
    end else if (w_move) begin
      w_p       = 2'd1;
      w_div_sel = DIV_MOVE;
    end
    w_accept   = (w_p != 2'd0) && ((r_state == ST_IDLE) || (w_p >= r_cur_p));
    // A zero divider behaves as divide-by-one so the phase still advances.
    w_div_last = (r_div == '0) ? '0 : r_div - DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_dir_q   <= '0;
      r_cur_p   <= 2'd0;
      r_dur_cnt <= '0;
      r_div     <= '0;
      r_div_cnt <= '0;
      r_phase   <= 8'd0;
    end else begin
      r_dir_q <= bus.direction_i;
      if (w_accept) begin
        r_state   <= ST_PLAY;
        r_cur_p   <= w_p;
        r_dur_cnt <= w_dur_sel;
        r_div     <= w_div_sel;
        r_div_cnt <= '0;
        r_phase   <= 8'd0;
      end else if (r_state == ST_PLAY) begin
        if (r_dur_cnt == '0) begin
          r_state   <= ST_IDLE;
          r_cur_p   <= 2'd0;
          r_div     <= '0;
          r_div_cnt <= '0;
          r_phase   <= 8'd0;
        end else begin
          r_dur_cnt <= r_dur_cnt - DUR_W'(1);
          if (r_div_cnt == w_div_last) begin
            r_div_cnt <= '0;
            r_phase   <= r_phase + 8'd1;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
      end
    end
  end

  assign bus.busy_o  = (r_state == ST_PLAY);
  assign bus.div_o   = r_div;
  assign bus.phase_o = r_phase;
  assign bus.wave_o  = r_phase[7] & ~bus.mute_i;

endmodule
